m23lc512: RTL and testbench

//  Synthesizable SPI-slave model of a Microchip 23LC512 64 KiB serial SRAM (SPI mode 0, single-bit I/O).

---
 rtl/m23lc512_pkg.sv | 25 ++
 rtl/m23lc512_sync.sv | 27 ++
 rtl/m23lc512.sv | 230 +++++++++++++++++++++++
 tb/tb_m23lc512.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/m23lc512_pkg.sv
// Shared opcodes, mode encodings and FSM state type for the 23LC512 SPI SRAM model.
package m23lc512_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDMR  = 8'h05;
    localparam logic [7:0] OP_WRMR  = 8'h01;
    localparam logic [7:0] OP_RSTIO = 8'hFF;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_PAGE = 2'b10;
    localparam logic [1:0] MODE_SEQ  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RDATA,
        ST_WDATA,
        ST_RDMR,
        ST_WRMR,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/m23lc512_sync.sv
// Two-flop pin synchronizer with rise/fall detection on the synchronized value.
module m23lc512_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [2:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= {3{RST_VAL}};
        end else begin
            pipe <= {pipe[1:0], d};
        end
    end

    assign q      = pipe[1];
    assign rise_c = pipe[1] & ~pipe[2];
    assign fall_c = ~pipe[1] & pipe[2];

endmodule

// File: rtl/m23lc512.sv
// Oversampled SPI mode-0 slave model of a 23LC512 serial SRAM.
// Define M23LC512_HOLD_EN to enable the HOLD_N_SIO3 pause function.
module m23lc512
    import m23lc512_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned PAGE_SIZE = 32
) (
    input  logic clock,
    input  logic RESET,
    input  logic CS_N,
    input  logic SCK,
    input  logic SI_SIO0,
    output logic SO_SIO1,
    input  logic HOLD_N_SIO3
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned PAGE_W = $clog2(PAGE_SIZE);
    localparam int unsigned CNT_W  = $clog2(ADDR_W);

    logic cs_n_s, si_s, sck_rise_c, sck_fall_c;
    logic unused_sck_q, unused_cs_r, unused_cs_f, unused_si_r, unused_si_f;
    logic hold_c, hold_q;
    logic rise_ev_c, fall_ev_c;

    m23lc512_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clock), .rst(RESET), .d(CS_N),
        .q(cs_n_s), .rise_c(unused_cs_r), .fall_c(unused_cs_f)
    );
    m23lc512_sync #(.RST_VAL(1'b0)) u_sync_sck (
        .clk(clock), .rst(RESET), .d(SCK),
        .q(unused_sck_q), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
    );
    m23lc512_sync #(.RST_VAL(1'b0)) u_sync_si (
        .clk(clock), .rst(RESET), .d(SI_SIO0),
        .q(si_s), .rise_c(unused_si_r), .fall_c(unused_si_f)
    );

`ifdef M23LC512_HOLD_EN
    logic hold_n_s, unused_hold_r, unused_hold_f;

    m23lc512_sync #(.RST_VAL(1'b1)) u_sync_hold (
        .clk(clock), .rst(RESET), .d(HOLD_N_SIO3),
        .q(hold_n_s), .rise_c(unused_hold_r), .fall_c(unused_hold_f)
    );

    assign hold_c = ~hold_n_s & ~cs_n_s;

    always_ff @(posedge clock) begin
        if (RESET) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= hold_c;
        end
    end
`else
    logic unused_hold_n;

    assign unused_hold_n = HOLD_N_SIO3;
    assign hold_c        = 1'b0;
    assign hold_q        = 1'b0;
`endif

    // While held, SCK edges are swallowed so every counter stays put.
    assign rise_ev_c = sck_rise_c & ~hold_c;
    assign fall_ev_c = sck_fall_c & ~hold_c;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         sh_q, sh_d;
    logic [ADDR_W-1:0]  addr_q, addr_d, addr_inc_c;
    logic [1:0]         mode_q, mode_d;
    logic               so_q, so_d, oe_q, oe_d;
    logic               is_wr_q, is_wr_d;
    logic [7:0]         sh_in_c, mode_byte_c, rd_q;
    logic               mem_we_c;
    logic [7:0]         mem [0:DEPTH-1];

    assign sh_in_c     = {sh_q, si_s};
    assign mode_byte_c = {mode_q, 6'b0};

    // Page mode wraps only the in-page offset; sequential wraps the full address.
    always_comb begin
        addr_inc_c = addr_q + ADDR_W'(1);
        if (mode_q == MODE_PAGE) begin
            addr_inc_c = {addr_q[ADDR_W-1:PAGE_W], addr_q[PAGE_W-1:0] + PAGE_W'(1)};
        end
    end

    always_ff @(posedge clock) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            addr_q  <= '0;
            mode_q  <= MODE_SEQ;
            so_q    <= 1'b0;
            oe_q    <= 1'b0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            so_q    <= so_d;
            oe_q    <= oe_d;
            is_wr_q <= is_wr_d;
        end
    end

    // Array is not reset; read port tracks the address register continuously.
    always_ff @(posedge clock) begin
        if (mem_we_c && !RESET) begin
            mem[addr_q] <= sh_in_c;
        end
        rd_q <= mem[addr_q];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        addr_d   = addr_q;
        mode_d   = mode_q;
        so_d     = so_q;
        oe_d     = oe_q;
        is_wr_d  = is_wr_q;
        mem_we_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!cs_n_s) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end
            end
            ST_CMD: begin
                if (rise_ev_c) begin
                    sh_d  = sh_in_c[6:0];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q[2:0] == 3'd7) begin
                        cnt_d = '0;
                        case (sh_in_c)
                            OP_READ:  begin state_d = ST_ADDR; is_wr_d = 1'b0; end
                            OP_WRITE: begin state_d = ST_ADDR; is_wr_d = 1'b1; end
                            OP_RDMR:  state_d = ST_RDMR;
                            OP_WRMR:  state_d = ST_WRMR;
                            OP_RSTIO: state_d = ST_IGNORE;
                            default:  state_d = ST_IGNORE;
                        endcase
                    end
                end
            end
            ST_ADDR: begin
                if (rise_ev_c) begin
                    addr_d = {addr_q[ADDR_W-2:0], si_s};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        cnt_d   = '0;
                        state_d = is_wr_q ? ST_WDATA : ST_RDATA;
                    end
                end
            end
            ST_RDATA: begin
                if (fall_ev_c) begin
                    so_d  = rd_q[~cnt_q[2:0]];
                    oe_d  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q[2:0] == 3'd7) begin
                        cnt_d  = '0;
                        addr_d = addr_inc_c;
                        if (mode_q == MODE_BYTE) begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
            end
            ST_WDATA: begin
                if (rise_ev_c) begin
                    sh_d  = sh_in_c[6:0];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q[2:0] == 3'd7) begin
                        cnt_d    = '0;
                        mem_we_c = 1'b1;
                        addr_d   = addr_inc_c;
                        if (mode_q == MODE_BYTE) begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
            end
            ST_RDMR: begin
                if (fall_ev_c) begin
                    so_d  = mode_byte_c[~cnt_q[2:0]];
                    oe_d  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRMR: begin
                if (rise_ev_c) begin
                    sh_d  = sh_in_c[6:0];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q[2:0] == 3'd7) begin
                        mode_d  = sh_q[6:5];
                        state_d = ST_IGNORE;
                    end
                end
            end
            ST_IGNORE: begin
                // Keeps the last read bit valid until the following SCK fall.
                if (fall_ev_c) begin
                    oe_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Deselect wins over everything except a commit already decided above.
        if (cs_n_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end
    end

    assign SO_SIO1 = (oe_q && !hold_q) ? so_q : 1'bz;

endmodule

// File: tb/tb_m23lc512.sv
// Directed bench for m23lc512: SPI mode-0 master tasks with hand-computed expectations.
module tb_m23lc512;

    localparam int HALF = 50;
    // SO is on a pulled-up net, so a released (high-Z) pin reads as all ones.
    localparam logic [7:0] HIZ = 8'hFF;

    logic clock, reset, cs_n, sck, si, hold_n;
    tri1  so;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] rx, ra, rb;

    m23lc512 dut (
        .clock(clock), .RESET(reset), .CS_N(cs_n), .SCK(sck),
        .SI_SIO0(si), .SO_SIO1(so), .HOLD_N_SIO3(hold_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int hi, input int lo, output logic [7:0] r);
        r = 8'h00;
        for (int i = hi; i >= lo; i--) begin
            si = tx[i];
            #HALF;
            r[i] = so;
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] dummy;
        xfer(b, 7, 0, dummy);
    endtask

    task automatic get(output logic [7:0] r);
        xfer(8'h00, 7, 0, r);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_end();
        #HALF;
        cs_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic cmd_addr(input logic [7:0] op, input logic [15:0] a);
        cs_begin();
        send(op);
        send(a[15:8]);
        send(a[7:0]);
    endtask

    task automatic set_mode(input logic [7:0] m);
        cs_begin();
        send(8'h01);
        send(m);
        cs_end();
    endtask

    initial begin
        reset = 1'b1; cs_n = 1'b1; sck = 1'b0; si = 1'b0; hold_n = 1'b1;
        repeat (4) @(posedge clock);
        #2 reset = 1'b0;
        #20;
        chk("reset_so_hiz", {7'd0, so}, 8'h01);

        // Mode register after reset is sequential.
        cs_begin(); send(8'h05);
        get(rx); chk("rdmr_reset", rx, 8'h40);
        get(rx); chk("rdmr_repeat", rx, 8'h40);
        cs_end();
        chk("cs_high_hiz", {7'd0, so}, 8'h01);

        // Byte mode: one byte, then the pin stays released.
        set_mode(8'h00);
        cmd_addr(8'h02, 16'h1234); send(8'hA5); cs_end();
        cmd_addr(8'h03, 16'h1234);
        get(rx); chk("byte_read", rx, 8'hA5);
        get(rx); chk("byte_second_hiz", rx, HIZ);
        cs_end();

        // Sequential mode with full address wrap.
        set_mode(8'h40);
        cmd_addr(8'h02, 16'hFFFF); send(8'h11); send(8'h22); cs_end();
        cmd_addr(8'h02, 16'h0020); send(8'h5A); cs_end();
        cmd_addr(8'h02, 16'h0101); send(8'h77); cs_end();
        cmd_addr(8'h03, 16'hFFFF);
        get(rx); chk("seq_ffff", rx, 8'h11);
        get(rx); chk("seq_wrap", rx, 8'h22);
        cs_end();
        cmd_addr(8'h03, 16'h0000); get(rx); chk("seq_0000", rx, 8'h22); cs_end();

        // Page mode wraps inside the 32-byte page.
        set_mode(8'h80);
        cs_begin(); send(8'h05); get(rx); chk("rdmr_page", rx, 8'h80); cs_end();
        cmd_addr(8'h02, 16'h001F); send(8'h33); send(8'h44); cs_end();
        cmd_addr(8'h03, 16'h001F);
        get(rx); chk("page_001f", rx, 8'h33);
        get(rx); chk("page_wrap", rx, 8'h44);
        cs_end();
        cmd_addr(8'h03, 16'h0020); get(rx); chk("page_0020_kept", rx, 8'h5A); cs_end();
        cmd_addr(8'h03, 16'h0000); get(rx); chk("page_0000", rx, 8'h44); cs_end();

        // Partial trailing byte is dropped at deselect.
        cmd_addr(8'h02, 16'h0100); send(8'h55); xfer(8'hAA, 7, 4, rx); cs_end();
        cmd_addr(8'h03, 16'h0100);
        get(rx); chk("partial_0100", rx, 8'h55);
        get(rx); chk("partial_0101_kept", rx, 8'h77);
        cs_end();

        // CS_N rises together with the 8th SCK rise: byte still commits.
        cmd_addr(8'h02, 16'h0200);
        xfer(8'hC3, 7, 1, rx);
        si = 1'b1;
        #HALF;
        sck = 1'b1; cs_n = 1'b1;
        #HALF;
        sck = 1'b0;
        #(4 * HALF);
        cmd_addr(8'h03, 16'h0200); get(rx); chk("simul_commit", rx, 8'hC3); cs_end();

        // Dual-read opcode is unsupported.
        cs_begin(); send(8'h3B); get(rx); chk("unknown_op_hiz", rx, HIZ); cs_end();

`ifdef M23LC512_HOLD_EN
        cmd_addr(8'h03, 16'h0100);
        xfer(8'h00, 7, 4, ra);
        #HALF;
        hold_n = 1'b0;
        #HALF;
        chk("hold_so_hiz", {7'd0, so}, 8'h01);
        repeat (3) begin
            sck = 1'b1; #HALF;
            sck = 1'b0; #HALF;
        end
        hold_n = 1'b1;
        #HALF;
        xfer(8'h00, 3, 0, rb);
        chk("hold_resume", {ra[7:4], rb[3:0]}, 8'h55);
        cs_end();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
